ysyx_210184_wb_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback path (req0) and the multi-cycle mul/div unit (req1).
- Round-robin arbitration with valid/ready handshakes and a registered write-port stage.
- Keeps a per-register busy scoreboard for destinations owned by in-flight mul/div operations, so decode can stall on RAW/WAW hazards.
- Sits between the writeback stage, the mul/div unit and the register file.

---
 rtl/ysyx_210184_wb_arbiter.sv | 79 +++++++
 tb/tb_ysyx_210184_wb_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_210184_wb_arbiter.sv
// Register-file write-port arbiter: round-robin between pipeline writeback (req0)
// and mul/div (req1), with a registered write stage and a mul/div busy scoreboard.
module ysyx_210184_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4:0]        req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4:0]        req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  output logic              issue_ready,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic              stall,
  output logic              w_ena,
  output logic [4:0]        w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic [NREG-1:0]   busy
);

  logic            last_grant;
  logic            grant1;
  logic            acc0;
  logic            acc1;
  logic            issue_acc;
  logic [NREG-1:0] busy_next;

  // req1 wins when alone, or when contending and req0 had the last contested grant
  assign grant1     = req1_valid & (~req0_valid | ~last_grant);
  assign req1_ready = ~rst & grant1;
  assign req0_ready = ~rst & req0_valid & ~grant1;

  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;

  assign issue_ready = ~rst & ~busy[issue_rd];
  assign issue_acc   = issue_valid & issue_ready & (issue_rd != 5'd0);

  assign stall = busy[rs1_addr] | busy[rs2_addr];

  // Clear on mul/div writeback first so a same-cycle claim of that register wins
  always_comb begin
    busy_next = busy;
    if (acc1) busy_next[req1_addr] = 1'b0;
    if (issue_acc) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ena      <= 1'b0;
      w_addr     <= 5'd0;
      w_data     <= '0;
      busy       <= '0;
      last_grant <= 1'b1;
    end else begin
      w_ena <= (acc0 && (req0_addr != 5'd0)) || (acc1 && (req1_addr != 5'd0));
      if (acc0) begin
        w_addr <= req0_addr;
        w_data <= req0_data;
      end else if (acc1) begin
        w_addr <= req1_addr;
        w_data <= req1_data;
      end
      // Rotation only advances on a contested grant
      if (req0_valid && req1_valid && (acc0 || acc1)) last_grant <= acc1;
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_ysyx_210184_wb_arbiter.sv
// Directed bench for ysyx_210184_wb_arbiter: expected writes are queued when a
// request is driven and compared one cycle later when the write port shows them.
module tb_ysyx_210184_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [63:0] req0_data, req1_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd, rs1_addr, rs2_addr;
  logic        stall, w_ena;
  logic [4:0]  w_addr;
  logic [63:0] w_data;
  logic [31:0] busy;

  typedef struct packed {
    logic        ena;
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t         sb_q[$];
  logic [4:0]  hold_addr;
  logic [63:0] hold_data;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  ysyx_210184_wb_arbiter #(.DATA_W(64), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .stall(stall),
    .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data), .busy(busy)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                                input logic iv, input logic [4:0] ird);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    issue_valid = iv; issue_rd = ird;
  endtask

  // One clock: check the expected grant, queue the expected write, then check it
  task automatic run_cycle(input logic exp_g0, input logic exp_g1);
    wr_t e;
    wr_t got;
    #1;
    if (req0_valid) check_output("req0_ready", req0_ready, exp_g0);
    if (req1_valid) check_output("req1_ready", req1_ready, exp_g1);
    e.ena = 1'b0;
    if (exp_g0 && req0_valid) begin
      e.ena = (req0_addr != 5'd0); hold_addr = req0_addr; hold_data = req0_data;
    end else if (exp_g1 && req1_valid) begin
      e.ena = (req1_addr != 5'd0); hold_addr = req1_addr; hold_data = req1_data;
    end
    e.addr = hold_addr;
    e.data = hold_data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_output("w_ena", w_ena, got.ena);
    check_output("w_addr", w_addr, got.addr);
    check_output("w_data", w_data, got.data);
  endtask

  initial begin
    rst = 1'b1;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    apply_stimulus(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2, 1'b0, 5'd5);
    #1;
    check_output("rst_req0_ready", req0_ready, 1'b0);
    check_output("rst_req1_ready", req1_ready, 1'b0);
    check_output("rst_issue_ready", issue_ready, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    apply_stimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd5);
    hold_addr = 5'd0;
    hold_data = 64'h0;
    #1;
    check_output("reset_w_ena", w_ena, 1'b0);
    check_output("reset_busy", busy, 32'h0);
    check_output("reset_issue_ready", issue_ready, 1'b1);
    check_output("reset_stall", stall, 1'b0);
    run_cycle(1'b0, 1'b0);

    $display("[TB] req0 only");
    apply_stimulus(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    run_cycle(1'b1, 1'b0);
    apply_stimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b0);

    $display("[TB] contention rotation");
    apply_stimulus(1'b1, 5'd3, 64'hA, 1'b1, 5'd7, 64'hB, 1'b0, 5'd0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b1);
    run_cycle(1'b1, 1'b0);
    apply_stimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'hB, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b1);
    apply_stimulus(1'b1, 5'd3, 64'hA, 1'b1, 5'd7, 64'hC, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b1);
    apply_stimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b0);

    $display("[TB] scoreboard");
    apply_stimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd9);
    #1;
    check_output("issue9_ready", issue_ready, 1'b1);
    run_cycle(1'b0, 1'b0);
    check_output("busy_after_issue9", busy, 32'h0000_0200);
    rs1_addr = 5'd9;
    #1;
    check_output("stall_rs1_9", stall, 1'b1);
    check_output("issue9_again_ready", issue_ready, 1'b0);
    run_cycle(1'b0, 1'b0);
    check_output("busy_refused_issue", busy, 32'h0000_0200);
    apply_stimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 64'hFF, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b1);
    check_output("busy_after_req1_9", busy, 32'h0);
    check_output("stall_cleared", stall, 1'b0);

    apply_stimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd4, 64'h44, 1'b1, 5'd4);
    rs1_addr = 5'd0;
    rs2_addr = 5'd4;
    run_cycle(1'b0, 1'b1);
    check_output("busy_set_wins", busy, 32'h0000_0010);
    check_output("stall_rs2_4", stall, 1'b1);
    apply_stimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 64'h55, 1'b1, 5'd0);
    #1;
    check_output("issue_x0_ready", issue_ready, 1'b1);
    run_cycle(1'b0, 1'b1);
    check_output("busy_x0_untouched", busy, 32'h0000_0010);

    $display("[TB] reset mid-flight");
    apply_stimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd6);
    run_cycle(1'b0, 1'b0);
    check_output("busy_4_6", busy, 32'h0000_0050);
    apply_stimulus(1'b1, 5'd2, 64'h22, 1'b1, 5'd6, 64'h66, 1'b0, 5'd0);
    run_cycle(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_output("midrst_req0_ready", req0_ready, 1'b0);
    check_output("midrst_req1_ready", req1_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    hold_addr = 5'd0;
    hold_data = 64'h0;
    check_output("midrst_busy", busy, 32'h0);
    check_output("midrst_w_ena", w_ena, 1'b0);
    check_output("midrst_w_addr", w_addr, 5'd0);
    check_output("midrst_w_data", w_data, 64'h0);
    run_cycle(1'b1, 1'b0);
    apply_stimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
